// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 frame constants and FSM state encoding.
// Imported by the peripheral front end and its helpers.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int OP_LEN   = 2;
  localparam int AD_LEN   = 5;
  localparam int TA_LEN   = 2;
  localparam int DATA_LEN = 16;

  typedef enum logic [3:0] {
    IDLE,
    START2,
    OP,
    PHYAD,
    REGAD,
    TA_RD,
    RD_SHIFT,
    TA_WR,
    WR_SHIFT
  } mdio_state_e;

endpackage

// File: rtl/mdio_sync_edge.sv
// 2-flop synchronizer with one-clk rise/fall pulses.
// Ports: clk, reset (async low), d in; rise, fall pulses out.
module mdio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/mdio_peripheral_ctrl.sv
// Clause-22 MDIO peripheral: frame decode, register file sequencing.
// Ports: clk/reset, MDC/MDIO_OUT in, MDIO_IN/OE out, ADDR/WR_*/RD_DATA.
module mdio_peripheral_ctrl #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  output logic        MDIO_IN,
  output logic        MDIO_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  input  logic [15:0] RD_DATA
);
  import mdio_pkg::*;

  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_SAT = PW'(PREAMBLE_MIN);
  localparam logic [4:0] OP_LAST = 5'(OP_LEN - 1);
  localparam logic [4:0] AD_LAST = 5'(AD_LEN - 1);
  localparam logic [4:0] TA_LAST = 5'(TA_LEN - 1);
  localparam logic [4:0] D_LAST  = 5'(DATA_LEN - 1);
  localparam logic [4:0] D_LEN   = 5'(DATA_LEN);

  logic rise, fall;
  logic md_s1, b;

  mdio_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic        ign_q, ign_d;
  logic [1:0]  op_q, op_d;
  logic [14:0] sr_q, sr_d;
  logic [15:0] rd_q, rd_d;
  logic        arm_q, arm_d;
  logic        ld1_q, ld1_d, ld2_q;
  logic        pend_q, pend_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wd_q, wd_d;
  logic        oe_q, oe_d;
  logic        mi_q, mi_d;
  logic        stb_q;

  mdio_sync_edge u_mdc (
    .clk   (clk),
    .reset (reset),
    .d     (MDC),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_s1   <= 1'b1;
      b       <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      ign_q   <= 1'b0;
      op_q    <= '0;
      sr_q    <= '0;
      rd_q    <= '0;
      arm_q   <= 1'b0;
      ld1_q   <= 1'b0;
      ld2_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      oe_q    <= 1'b0;
      mi_q    <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      md_s1   <= MDIO_OUT;
      b       <= md_s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      ign_q   <= ign_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
      arm_q   <= arm_d;
      ld1_q   <= ld1_d;
      ld2_q   <= ld1_q;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      oe_q    <= oe_d;
      mi_q    <= mi_d;
      stb_q   <= pend_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    ign_d   = ign_q;
    op_d    = op_q;
    sr_d    = sr_q;
    rd_d    = rd_q;
    arm_d   = arm_q;
    ld1_d   = 1'b0;
    pend_d  = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    oe_d    = oe_q;
    mi_d    = mi_q;
    // register file data is valid one clk after ADDR moves
    if (ld2_q) rd_d = RD_DATA;
    if (rise) sr_d = {sr_q[13:0], b};
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (b) begin
            if (pre_q != PRE_SAT) pre_d = pre_q + 1'b1;
          end else begin
            pre_d = '0;
            if (pre_q >= PRE_SAT) state_d = START2;
          end
        end
      end
      START2: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = (b == ST[0]) ? OP : IDLE;
        end
      end
      OP: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == OP_LAST) begin
            cnt_d = '0;
            op_d  = {sr_q[0], b};
            if ({sr_q[0], b} == OP_READ ||
                {sr_q[0], b} == OP_WRITE)
              state_d = PHYAD;
            else
              state_d = IDLE;
          end
        end
      end
      PHYAD: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == AD_LAST) begin
            cnt_d   = '0;
            ign_d   = {sr_q[3:0], b} != PHY_ADDR;
            state_d = REGAD;
          end
        end
      end
      REGAD: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == AD_LAST) begin
            cnt_d = '0;
            arm_d = 1'b0;
            if (!ign_q) addr_d = {sr_q[3:0], b};
            if (op_q == OP_READ) begin
              ld1_d   = 1'b1;
              state_d = TA_RD;
            end else begin
              state_d = TA_WR;
            end
          end
        end
      end
      TA_RD: begin
        if (rise) arm_d = 1'b1;
        if (fall && arm_q) begin
          cnt_d   = '0;
          state_d = RD_SHIFT;
          if (!ign_q) begin
            oe_d = 1'b1;
            mi_d = 1'b0;
          end
        end
      end
      RD_SHIFT: begin
        if (fall) begin
          if (cnt_q == D_LEN) begin
            oe_d    = 1'b0;
            mi_d    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
            rd_d  = {rd_q[14:0], 1'b0};
            if (!ign_q) mi_d = rd_q[15];
          end
        end
      end
      TA_WR: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q != TA_LAST) begin
            if (b != TA_WRITE[1]) state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = (b == TA_WRITE[0]) ? WR_SHIFT : IDLE;
          end
        end
      end
      WR_SHIFT: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == D_LAST) begin
            state_d = IDLE;
            if (!ign_q) begin
              wd_d   = {sr_q, b};
              pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MDIO_IN = mi_q;
  assign MDIO_OE = oe_q;
  assign ADDR    = addr_q;
  assign WR_DATA = wd_q;
  assign WR_STB  = stb_q;

endmodule

// File: doc/mdio_peripheral_ctrl.md
Name: mdio_peripheral_ctrl

Overview:
- Clause-22 MDIO peripheral (slave) front end: decodes serial MDIO frames from the station manager and sequences accesses to the 32x16 PHY register file.
- Drives the register file's ADDR/WR_DATA/WR_STB and samples its RD_DATA, which has a 1-cycle registered read latency.
- Runs entirely on the system clock; MDC is treated as a sampled input, not as a clock.

Parameters:
- PHY_ADDR, 5'd1, PHY address this peripheral answers to.
- PREAMBLE_MIN, 32, consecutive '1' bits required before a start delimiter is accepted.

Ports:
- clk  input  1  system clock; must be at least 8x the MDC frequency.
- reset  input  1  asynchronous, active-low reset.
- MDC  input  1  management clock from the controller, asynchronous to clk.
- MDIO_OUT  input  1  MDIO line value driven by the controller.
- MDIO_IN  output  1  value this block drives onto MDIO.
- MDIO_OE  output  1  tristate enable for MDIO_IN.
- ADDR  output  5  register address to the PHY register file.
- WR_DATA  output  16  write data to the register file.
- WR_STB  output  1  single-cycle write strobe.
- RD_DATA  input  16  register file read data, valid 1 clk after ADDR changes.

Behaviour:
- Reset (reset=0, async): state IDLE, preamble count 0; ADDR=0, WR_DATA=0, WR_STB=0, MDIO_OE=0, MDIO_IN=1.
- Input sampling:
  - MDC and MDIO_OUT each pass through a 2-flop synchronizer.
  - MDC rise and fall are one-clk pulses from the synchronized MDC.
  - MDIO_OUT is sampled only on MDC-rise pulses.
- State IDLE (preamble hunt):
  - Each sampled '1' increments a saturating counter; each '0' clears it.
  - A '0' seen with count >= PREAMBLE_MIN goes to START2; otherwise stay in IDLE.
- START2: sampled bit must be 1; otherwise go to IDLE with count 0.
- OP: 2 bits. 10 = read, 01 = write; 00 or 11 aborts to IDLE.
- PHYAD: 5 bits MSB-first. A mismatch with PHY_ADDR sets an ignore flag; the frame is still tracked to its end, with no strobes and no OE.
- REGAD: 5 bits MSB-first.
  - On the 5th bit, update ADDR at that clk if not ignored.
  - ADDR then holds until the next frame's REGAD.
- Read path:
  - TA_RD: first TA bit period leaves OE=0.
  - On the MDC fall after the first TA rise, set OE=1 and MDIO_IN=0 (if not ignored).
  - The read shift register loads RD_DATA exactly 2 clks after the ADDR update, so it completes before that fall.
  - RD_SHIFT: on each subsequent MDC fall, MDIO_IN takes the next data bit MSB-first; 16 bits are sent.
  - On the MDC fall after the 16th data rise: OE=0, MDIO_IN=1, go to IDLE.
- Write path:
  - TA_WR: the 2 sampled bits must be 1,0; otherwise abort to IDLE with no strobe.
  - WR_SHIFT: 16 bits MSB-first into the shift register.
  - On the 16th sample: WR_DATA = shifted value, and WR_STB=1 for exactly one clk the following cycle (if not ignored); then go to IDLE.
- Preamble after a frame: the preamble counter restarts at 0 after every frame or abort.
  - Frames may be back-to-back only with a fresh preamble of at least PREAMBLE_MIN bits.
- Reset mid-frame: all outputs return to reset values immediately; any pending WR_STB is discarded.
- OE ownership: OE is never 1 outside TA_RD/RD_SHIFT.
- Write and read never overlap: at most one WR_STB per frame.

Decomposition:
- Package mdio_pkg:
  - opcode constants OP_READ=2'b10 and OP_WRITE=2'b01;
  - ST=2'b01;
  - TA_WRITE=2'b10;
  - state enumeration (IDLE, START2, OP, PHYAD, REGAD, TA_RD, RD_SHIFT, TA_WR, WR_SHIFT);
  - field lengths.
- Sub-module mdio_sync_edge: 2-flop synchronizer plus rise/fall pulse generator, instantiated for MDC; a plain synchronizer is used for MDIO_OUT.

Test Plan:
- Write: 32x'1' preamble, 01, 01, PHYAD=00001, REGAD=00101, TA=10, data 16'hA5A5.
  -> ADDR=5, WR_DATA=16'hA5A5, and WR_STB high exactly 1 clk after the 16th MDC rise.
- Read after that write: preamble, 01, 10, 00001, 00101 (register model returns stored value).
  -> OE rises at the first-TA fall with MDIO_IN=0, then 16'hA5A5 is shifted MSB-first on falls, then OE=0.
- PHYAD=00010 with write data 16'h1234.
  -> no WR_STB, OE stays 0; a following valid frame is still decoded.
- Preamble of 20 ones followed by a valid write.
  -> ignored, no WR_STB; then a 32-one preamble frame succeeds.
- Opcode 11, or write TA=11.
  -> abort, no WR_STB, OE=0, return to IDLE.
- reset=0 asserted during RD_SHIFT, bit 7.
  -> OE=0, MDIO_IN=1, ADDR=0 immediately; after release, a full write frame produces WR_STB.
